// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control bus between the multicycle FSM and the datapath
interface multicycle_control_fsm_if;
    logic [5:0] Op;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       IllegalOp;
    logic [3:0] State;

    // FSM side: takes the opcode, drives every control line
    modport master (
        input  Op,
        output PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp, State
    );

    // datapath side: supplies the opcode, consumes the controls
    modport slave (
        output Op,
        input  PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp, State
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control FSM for the multicycle MIPS datapath
module multicycle_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                        clk,
    input  logic                        reset_n,
    multicycle_control_fsm_if.master    bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_UNUSED0 = 4'd12,
        S_UNUSED1 = 4'd13,
        S_UNUSED2 = 4'd14,
        S_RESET   = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    state_t state;
    state_t next_state;
    ctrl_t  ctrl_d;
    ctrl_t  ctrl_q;
    logic   illegal_d;
    logic   illegal_q;
    logic   op_known;

    assign op_known = (bus.Op == OP_RTYPE) || (bus.Op == OP_LW) || (bus.Op == OP_SW) ||
                      (bus.Op == OP_BEQ) || (bus.Op == OP_ADDI) || (bus.Op == OP_J);

    // state and registered outputs; async reset abandons any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RESET;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= next_state;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    // next-state logic; opcode only matters in DECODE and MEMADR
    always_comb begin
        next_state = S_FETCH;
        unique case (state)
            S_FETCH:   next_state = S_DECODE;
            S_DECODE: begin
                if (bus.Op == OP_LW || bus.Op == OP_SW) next_state = S_MEMADR;
                else if (bus.Op == OP_RTYPE)            next_state = S_EXECUTE;
                else if (bus.Op == OP_BEQ)              next_state = S_BRANCH;
                else if (bus.Op == OP_ADDI)             next_state = S_ADDIEX;
                else if (bus.Op == OP_J)                next_state = S_JUMP;
                else                                    next_state = S_FETCH;
            end
            S_MEMADR:  next_state = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next_state = S_MEMWB;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    // output decode from next_state so registered outputs line up with State
    always_comb begin
        ctrl_d    = '0;
        illegal_d = (state == S_DECODE) && !op_known;
        unique case (next_state)
            S_FETCH: begin
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.pc_write  = 1'b1;
            end
            S_DECODE:  ctrl_d.alu_src_b = 2'b11;
            S_MEMADR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            S_MEMRD:   ctrl_d.iord = 1'b1;
            S_MEMWB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_d.iord      = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_op        = 2'b01;
                ctrl_d.pc_src        = 2'b01;
                ctrl_d.pc_write_cond = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            S_ADDIWB:  ctrl_d.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = 2'b10;
            end
            default:   ctrl_d = '0;
        endcase
    end

    assign bus.PCWrite     = ctrl_q.pc_write;
    assign bus.PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.IRWrite     = ctrl_q.ir_write;
    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.PCSrc       = ctrl_q.pc_src;
    assign bus.IllegalOp   = illegal_q;
    assign bus.State       = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   mw_cnt;
    int   rw_cnt;
    int   ill_cnt;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // {PCWrite,PCWriteCond,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
    localparam logic [14:0] O_NONE    = 15'b0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [14:0] O_FETCH   = 15'b1_0_0_0_1_0_0_0_0_01_00_00;
    localparam logic [14:0] O_DECODE  = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [14:0] O_MEMADR  = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [14:0] O_MEMRD   = 15'b0_0_1_0_0_0_0_0_0_00_00_00;
    localparam logic [14:0] O_MEMWB   = 15'b0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [14:0] O_MEMWR   = 15'b0_0_1_1_0_0_0_0_0_00_00_00;
    localparam logic [14:0] O_EXECUTE = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [14:0] O_ALUWB   = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [14:0] O_BRANCH  = 15'b0_1_0_0_0_0_0_0_1_00_01_01;
    localparam logic [14:0] O_ADDIEX  = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [14:0] O_ADDIWB  = 15'b0_0_0_0_0_0_0_1_0_00_00_00;
    localparam logic [14:0] O_JUMP    = 15'b1_0_0_0_0_0_0_0_0_00_00_10;

    logic [14:0] obs;
    assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemWrite, bus.IRWrite,
                  bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ALUOp, bus.PCSrc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string tag, input logic [3:0] st, input logic [14:0] outs,
                             input logic ill);
        total++;
        assert (bus.State === st) else begin
            bad++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, bus.State, st);
        end
        total++;
        assert (obs === outs) else begin
            bad++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, outs);
        end
        total++;
        assert (bus.IllegalOp === ill) else begin
            bad++;
            $error("FAIL %s illegal observed=%b expected=%b", tag, bus.IllegalOp, ill);
        end
        mw_cnt  += int'(bus.MemWrite);
        rw_cnt  += int'(bus.RegWrite);
        ill_cnt += int'(bus.IllegalOp);
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [14:0] outs,
                        input logic ill);
        @(posedge clk);
        #2;
        check_now(tag, st, outs, ill);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        mw_cnt  = 0;
        rw_cnt  = 0;
        ill_cnt = 0;
        reset_n = 1'b0;
        bus.Op  = 6'b000000;

        // held in reset across clock edges
        step("reset_hold", 4'd15, O_NONE, 1'b0);
        step("reset_hold2", 4'd15, O_NONE, 1'b0);
        reset_n = 1'b1;
        step("first_fetch", 4'd0, O_FETCH, 1'b0);

        // LW: 0,1,2,3,4,0 ; Op garbage in MEMRD must be ignored
        bus.Op = 6'b100011;
        step("lw_decode", 4'd1, O_DECODE, 1'b0);
        step("lw_memadr", 4'd2, O_MEMADR, 1'b0);
        step("lw_memrd", 4'd3, O_MEMRD, 1'b0);
        bus.Op = 6'b111111;
        step("lw_memwb", 4'd4, O_MEMWB, 1'b0);
        step("lw_fetch", 4'd0, O_FETCH, 1'b0);

        // BEQ: 0,1,8,0
        bus.Op = 6'b000100;
        step("beq_decode", 4'd1, O_DECODE, 1'b0);
        step("beq_branch", 4'd8, O_BRANCH, 1'b0);
        step("beq_fetch", 4'd0, O_FETCH, 1'b0);

        // J: 0,1,11,0
        bus.Op = 6'b000010;
        step("j_decode", 4'd1, O_DECODE, 1'b0);
        step("j_jump", 4'd11, O_JUMP, 1'b0);
        step("j_fetch", 4'd0, O_FETCH, 1'b0);

        // illegal: 0,1,0 with a single IllegalOp pulse
        bus.Op  = 6'b111111;
        ill_cnt = 0;
        mw_cnt  = 0;
        rw_cnt  = 0;
        step("ill_decode", 4'd1, O_DECODE, 1'b0);
        step("ill_fetch", 4'd0, O_FETCH, 1'b1);

        // back-to-back SW, ADDI, R-type
        bus.Op = 6'b101011;
        step("sw_decode", 4'd1, O_DECODE, 1'b0);
        total++;
        assert (ill_cnt == 1 && mw_cnt == 0 && rw_cnt == 0) else begin
            bad++;
            $error("FAIL ill_pulse observed ill=%0d mw=%0d rw=%0d expected 1/0/0",
                   ill_cnt, mw_cnt, rw_cnt);
        end
        mw_cnt = 0;
        rw_cnt = 0;
        step("sw_memadr", 4'd2, O_MEMADR, 1'b0);
        step("sw_memwr", 4'd5, O_MEMWR, 1'b0);
        step("sw_fetch", 4'd0, O_FETCH, 1'b0);
        bus.Op = 6'b001000;
        step("addi_decode", 4'd1, O_DECODE, 1'b0);
        step("addi_ex", 4'd9, O_ADDIEX, 1'b0);
        step("addi_wb", 4'd10, O_ADDIWB, 1'b0);
        step("addi_fetch", 4'd0, O_FETCH, 1'b0);
        bus.Op = 6'b000000;
        step("r_decode", 4'd1, O_DECODE, 1'b0);
        step("r_execute", 4'd6, O_EXECUTE, 1'b0);
        step("r_aluwb", 4'd7, O_ALUWB, 1'b0);
        step("r_fetch", 4'd0, O_FETCH, 1'b0);
        total++;
        assert (mw_cnt == 1) else begin
            bad++;
            $error("FAIL b2b_memwrite observed=%0d expected=1", mw_cnt);
        end
        total++;
        assert (rw_cnt == 2) else begin
            bad++;
            $error("FAIL b2b_regwrite observed=%0d expected=2", rw_cnt);
        end

        // async reset in the middle of EXECUTE
        step("rst_decode", 4'd1, O_DECODE, 1'b0);
        step("rst_execute", 4'd6, O_EXECUTE, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check_now("async_reset", 4'd15, O_NONE, 1'b0);
        step("reset_again", 4'd15, O_NONE, 1'b0);
        reset_n = 1'b1;
        step("refetch", 4'd0, O_FETCH, 1'b0);
        step("redecode", 4'd1, O_DECODE, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // absolute time bound so the run always terminates
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
